// File: rtl/grf_pkg.sv
// Shared definitions for the register-file write arbiter.
//   GRF_AW / GRF_DW : register address and data widths
//   GRF_ZERO        : hard-wired zero register; writes to it are discarded
//   PORT_WB/PORT_MD : requester indices (pipeline writeback, multi-cycle unit)
package grf_pkg;
  localparam int GRF_AW   = 5;
  localparam int GRF_DW   = 32;
  localparam int GRF_ZERO = 0;
  localparam int PORT_WB  = 0;
  localparam int PORT_MD  = 1;
endpackage

// File: rtl/grf_wr_arbiter_if.sv
// Bundle of the arbiter's request, write-port and hazard-query signals.
//   p0_* / p1_*      : valid/ready/addr/data write request per requester
//   grf_we/a3/wd     : register-file write port
//   q_a1/q_a2        : decode read addresses; haz1/haz2 the matching hazard flags
// Modport slave is the arbiter, master is its environment.
interface grf_wr_arbiter_if
  import grf_pkg::*;
#(
  parameter int AW = GRF_AW,
  parameter int DW = GRF_DW
);
  logic          p0_valid;
  logic          p0_ready;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_data;
  logic          p1_valid;
  logic          p1_ready;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_data;
  logic          grf_we;
  logic [AW-1:0] grf_a3;
  logic [DW-1:0] grf_wd;
  logic [AW-1:0] q_a1;
  logic [AW-1:0] q_a2;
  logic          haz1;
  logic          haz2;

  modport slave (
    input  p0_valid, p0_addr, p0_data,
    input  p1_valid, p1_addr, p1_data,
    input  q_a1, q_a2,
    output p0_ready, p1_ready,
    output grf_we, grf_a3, grf_wd,
    output haz1, haz2
  );

  modport master (
    output p0_valid, p0_addr, p0_data,
    output p1_valid, p1_addr, p1_data,
    output q_a1, q_a2,
    input  p0_ready, p1_ready,
    input  grf_we, grf_a3, grf_wd,
    input  haz1, haz2
  );
endinterface

// File: rtl/grf_wr_slot.sv
// One-entry write buffer (valid/addr/data).
//   clk, reset (async, active-low)
//   load    : capture in_addr/in_data and mark valid (wins over clear, so a
//             granted slot can be refilled in the same cycle)
//   clear   : drop the entry (it has been granted)
//   valid/addr/data : current contents
//   match1/match2   : entry valid and its address equals q_a1/q_a2
module grf_wr_slot
  import grf_pkg::*;
#(
  parameter int AW = GRF_AW,
  parameter int DW = GRF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          clear,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] q_a1,
  input  logic [AW-1:0] q_a2,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          match1,
  output logic          match2
);
  logic          valid_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      addr_reg  <= in_addr;
      data_reg  <= in_data;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid  = valid_reg;
  assign addr   = addr_reg;
  assign data   = data_reg;
  assign match1 = valid_reg && (addr_reg == q_a1);
  assign match2 = valid_reg && (addr_reg == q_a2);
endmodule

// File: rtl/grf_wr_arbiter.sv
// Shares the register file's single write port between the pipeline
// writeback (port 0) and the multi-cycle unit (port 1). Each port has a
// one-entry buffer; the older buffered write is granted each cycle and
// committed to the registered write port on the following edge.
//   clk, reset (async, active-low)
//   bus : grf_wr_arbiter_if.slave -- requests, write port, hazard queries
module grf_wr_arbiter
  import grf_pkg::*;
#(
  parameter int AW = GRF_AW,
  parameter int DW = GRF_DW
) (
  input  logic              clk,
  input  logic              reset,
  grf_wr_arbiter_if.slave   bus
);
  logic          in_valid  [2];
  logic [AW-1:0] in_addr   [2];
  logic [DW-1:0] in_data   [2];
  logic          slot_v    [2];
  logic [AW-1:0] slot_addr [2];
  logic [DW-1:0] slot_data [2];
  logic          slot_m1   [2];
  logic          slot_m2   [2];
  logic          grant     [2];
  logic          ready     [2];
  logic          load      [2];

  // Set when slot 1 holds the older entry; only meaningful with both valid.
  logic          age_reg;
  logic          age_next;
  logic          grf_we_reg;
  logic [AW-1:0] grf_a3_reg;
  logic [DW-1:0] grf_wd_reg;

  logic          any_grant;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;

  assign in_valid[PORT_WB] = bus.p0_valid;
  assign in_addr[PORT_WB]  = bus.p0_addr;
  assign in_data[PORT_WB]  = bus.p0_data;
  assign in_valid[PORT_MD] = bus.p1_valid;
  assign in_addr[PORT_MD]  = bus.p1_addr;
  assign in_data[PORT_MD]  = bus.p1_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign ready[gi] = !slot_v[gi] || grant[gi];
      assign load[gi]  = in_valid[gi] && ready[gi];

      grf_wr_slot #(.AW(AW), .DW(DW)) u_slot (
        .clk     (clk),
        .reset   (reset),
        .load    (load[gi]),
        .clear   (grant[gi]),
        .in_addr (in_addr[gi]),
        .in_data (in_data[gi]),
        .q_a1    (bus.q_a1),
        .q_a2    (bus.q_a2),
        .valid   (slot_v[gi]),
        .addr    (slot_addr[gi]),
        .data    (slot_data[gi]),
        .match1  (slot_m1[gi]),
        .match2  (slot_m2[gi])
      );
    end
  endgenerate

  // Oldest-first; when both were loaded together age_reg is 0, so port 0 wins.
  assign grant[PORT_WB] = slot_v[PORT_WB] && (!slot_v[PORT_MD] || !age_reg);
  assign grant[PORT_MD] = slot_v[PORT_MD] && (!slot_v[PORT_WB] ||  age_reg);

  // Slot 1 is older next cycle exactly when it survives this edge untouched:
  // any grant this cycle went to slot 0, so a refilled slot 0 is younger.
  assign age_next = slot_v[PORT_MD] && !grant[PORT_MD] && !load[PORT_MD];

  assign any_grant = grant[PORT_WB] || grant[PORT_MD];
  assign gnt_addr  = grant[PORT_WB] ? slot_addr[PORT_WB] : slot_addr[PORT_MD];
  assign gnt_data  = grant[PORT_WB] ? slot_data[PORT_WB] : slot_data[PORT_MD];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age_reg    <= 1'b0;
      grf_we_reg <= 1'b0;
      grf_a3_reg <= '0;
      grf_wd_reg <= '0;
    end else begin
      age_reg <= age_next;
      // A granted write to the zero register retires silently.
      if (any_grant && (gnt_addr != AW'(GRF_ZERO))) begin
        grf_we_reg <= 1'b1;
        grf_a3_reg <= gnt_addr;
        grf_wd_reg <= gnt_data;
      end else begin
        grf_we_reg <= 1'b0;
      end
    end
  end

  assign bus.p0_ready = ready[PORT_WB];
  assign bus.p1_ready = ready[PORT_MD];
  assign bus.grf_we   = grf_we_reg;
  assign bus.grf_a3   = grf_a3_reg;
  assign bus.grf_wd   = grf_wd_reg;

  assign bus.haz1 = (bus.q_a1 != AW'(GRF_ZERO)) &&
                    (slot_m1[PORT_WB] || slot_m1[PORT_MD] ||
                     (grf_we_reg && (grf_a3_reg == bus.q_a1)));
  assign bus.haz2 = (bus.q_a2 != AW'(GRF_ZERO)) &&
                    (slot_m2[PORT_WB] || slot_m2[PORT_MD] ||
                     (grf_we_reg && (grf_a3_reg == bus.q_a2)));
endmodule

// File: tb/tb_grf_wr_arbiter.sv
module tb_grf_wr_arbiter;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  grf_wr_arbiter_if bus ();

  grf_wr_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: each port holds at most one pending write stamped with
  // the cycle it was accepted; the smallest stamp is served first, port 0 on ties.
  bit          mv  [2];
  logic [4:0]  ma  [2];
  logic [31:0] md  [2];
  int          mts [2];
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  int          cyc = 0;
  logic [31:0] rf [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (mv[0] && mv[1]) return (mts[0] <= mts[1]) ? 0 : 1;
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction

  function automatic bit model_haz(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    return (mv[0] && ma[0] == q) || (mv[1] && ma[1] == q) || (m_we && m_a3 == q);
  endfunction

  task automatic model_reset();
    mv[0] = 0; mv[1] = 0;
    m_we = 0; m_a3 = '0; m_wd = '0;
  endtask

  task automatic drive(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.p0_valid = v0; bus.p0_addr = a0; bus.p0_data = d0;
    bus.p1_valid = v1; bus.p1_addr = a1; bus.p1_data = d1;
  endtask

  // One clock cycle: compare outputs with the model, advance across the edge.
  task automatic cycle();
    int g;
    bit r0, r1, acc0, acc1;
    logic [4:0] a0, a1;
    logic [31:0] d0, d1;
    #1;
    g  = model_grant();
    r0 = !mv[0] || (g == 0);
    r1 = !mv[1] || (g == 1);
    chk("model_p0_ready", 32'(bus.p0_ready), 32'(r0));
    chk("model_p1_ready", 32'(bus.p1_ready), 32'(r1));
    chk("model_haz1", 32'(bus.haz1), 32'(model_haz(bus.q_a1)));
    chk("model_haz2", 32'(bus.haz2), 32'(model_haz(bus.q_a2)));
    chk("model_we", 32'(bus.grf_we), 32'(m_we));
    if (m_we) begin
      chk("model_a3", 32'(bus.grf_a3), 32'(m_a3));
      chk("model_wd", bus.grf_wd, m_wd);
    end
    if (bus.grf_we) rf[bus.grf_a3] = bus.grf_wd;
    acc0 = bus.p0_valid && r0; a0 = bus.p0_addr; d0 = bus.p0_data;
    acc1 = bus.p1_valid && r1; a1 = bus.p1_addr; d1 = bus.p1_data;
    @(posedge clk);
    if (g >= 0) begin
      m_we = (ma[g] != 5'd0);
      if (m_we) begin m_a3 = ma[g]; m_wd = md[g]; end
      mv[g] = 0;
    end else begin
      m_we = 0;
    end
    if (acc0) begin mv[0] = 1; ma[0] = a0; md[0] = d0; mts[0] = cyc; end
    if (acc1) begin mv[1] = 1; ma[1] = a1; md[1] = d1; mts[1] = cyc; end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    bus.q_a1 = 5'd5; bus.q_a2 = 5'd7;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_we", 32'(bus.grf_we), 0);
    chk("rst_a3", 32'(bus.grf_a3), 0);
    chk("rst_wd", bus.grf_wd, 0);
    chk("rst_ready", {bus.p0_ready, bus.p1_ready}, 32'h3);
    chk("rst_haz", {bus.haz1, bus.haz2}, 0);
    reset = 1'b1;
    $display("step reset released");

    // Single write with hazard tracking until commit.
    bus.q_a1 = 5'd5; bus.q_a2 = 5'd0;
    drive(1, 5, 32'h1234, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("t2_haz_pending", 32'(bus.haz1), 1);
    chk("t2_we_early", 32'(bus.grf_we), 0);
    cycle();
    #1 chk("t2_we", 32'(bus.grf_we), 1);
    chk("t2_a3", 32'(bus.grf_a3), 5);
    chk("t2_wd", bus.grf_wd, 32'h1234);
    chk("t2_haz_commit", 32'(bus.haz1), 1);
    cycle();
    #1 chk("t2_haz_clear", 32'(bus.haz1), 0);
    cycle();
    $display("step single write $5 done");

    // Same-cycle writes to one register: port 0 first.
    drive(1, 7, 32'hA, 1, 7, 32'hB);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    #1 chk("t3_first", bus.grf_wd, 32'hA);
    cycle();
    #1 chk("t3_second", bus.grf_wd, 32'hB);
    chk("t3_a3", 32'(bus.grf_a3), 7);
    cycle();
    chk("t3_final_r7", rf[7], 32'hB);
    $display("step same-address pair done");

    // Port 1 becomes older than a refilled port 0; port 0 must wait.
    drive(1, 20, 32'h20, 1, 3, 32'h3);
    cycle();
    drive(1, 4, 32'h4, 0, 0, 0);
    cycle();
    drive(1, 6, 32'h6, 0, 0, 0);
    #1 chk("t4_p0_stall", 32'(bus.p0_ready), 0);
    chk("t4_c1", bus.grf_wd, 32'h20);
    cycle();
    #1 chk("t4_p0_resume", 32'(bus.p0_ready), 1);
    chk("t4_c2", bus.grf_wd, 32'h3);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("t4_c3", bus.grf_wd, 32'h4);
    cycle();
    #1 chk("t4_c4", bus.grf_wd, 32'h6);
    chk("t4_c4_we", 32'(bus.grf_we), 1);
    cycle();
    $display("step age ordering done");

    // Write to the zero register: never committed, never a hazard.
    bus.q_a1 = 5'd0; bus.q_a2 = 5'd0;
    drive(1, 0, 32'hFFFF, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_we", 32'(bus.grf_we), 0);
      chk("t5_haz", 32'(bus.haz1), 0);
      cycle();
    end
    $display("step zero-register write done");

    // Back-to-back stream on port 0.
    bus.q_a1 = 5'd9; bus.q_a2 = 5'd12;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1, 5'(8 + i), 32'h100 + 32'(i), 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0);
      #1 chk("t6_ready", 32'(bus.p0_ready), 1);
      if (i >= 2) chk("t6_commit", bus.grf_wd, 32'h100 + 32'(i - 2));
      cycle();
    end
    $display("step stream of 8 done");

    // Asynchronous reset with both slots full and a commit on the port.
    bus.q_a1 = 5'd11; bus.q_a2 = 5'd12;
    drive(1, 11, 32'h11, 1, 12, 32'h12);
    cycle();
    drive(1, 13, 32'h13, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #2 chk("t1_pre_we", 32'(bus.grf_we), 1);
    reset = 1'b0;
    #1 chk("t1_we", 32'(bus.grf_we), 0);
    chk("t1_ready", {bus.p0_ready, bus.p1_ready}, 32'h3);
    chk("t1_haz", {bus.haz1, bus.haz2}, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    $display("step mid-stream reset done");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      bus.q_a1 = 5'($urandom_range(0, 7));
      bus.q_a2 = 5'($urandom_range(0, 7));
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) cycle();
    $display("step random traffic done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
